// File: rtl/inst_pair_queue.sv
// inst_pair_queue: fetch-to-decode instruction-pair FIFO with branch flush; define IPQ_BYPASS_EN for a zero-latency empty-queue bypass
module inst_pair_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [PC_W-1:0]            push_pc_i,
  input  logic [INST_W-1:0]          push_first_inst_i,
  input  logic [INST_W-1:0]          push_second_inst_i,
  input  logic                       stall_i,
  output logic                       out_valid_o,
  output logic [PC_W-1:0]            out_pc_o,
  output logic [INST_W-1:0]          out_first_inst_o,
  output logic [INST_W-1:0]          out_second_inst_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic [INST_W-1:0] first_q  [DEPTH];
  logic [INST_W-1:0] second_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              empty, full, push_fire, byp_take, wr_en, rd_en;

  assign empty        = (occ_q == '0);
  assign full         = (occ_q == OW'(DEPTH));
  assign push_ready_o = ~full;
  assign push_fire    = push_valid_i & push_ready_o & ~flush_i;
  assign rd_en        = ~empty & ~stall_i & ~flush_i;
  assign wr_en        = push_fire & ~byp_take;
  assign occupancy_o  = occ_q;

`ifdef IPQ_BYPASS_EN
  logic byp;
  // Empty queue: a new pair goes straight to decode; it is only stored if decode stalls.
  assign byp               = empty & push_valid_i & ~flush_i & rst_ni;
  assign byp_take          = byp & ~stall_i;
  assign out_valid_o       = ~empty | byp;
  assign out_pc_o          = ~out_valid_o ? '0 : byp ? push_pc_i : pc_q[rd_ptr_q];
  assign out_first_inst_o  = ~out_valid_o ? '0 : byp ? push_first_inst_i : first_q[rd_ptr_q];
  assign out_second_inst_o = ~out_valid_o ? '0 : byp ? push_second_inst_i : second_q[rd_ptr_q];
`else
  assign byp_take          = 1'b0;
  assign out_valid_o       = ~empty;
  assign out_pc_o          = out_valid_o ? pc_q[rd_ptr_q] : '0;
  assign out_first_inst_o  = out_valid_o ? first_q[rd_ptr_q] : '0;
  assign out_second_inst_o = out_valid_o ? second_q[rd_ptr_q] : '0;
`endif

  // Next pointers and occupancy; flush discards everything, including this cycle's push/pop.
  always_comb begin
    rd_ptr_d = flush_i ? '0 : rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = flush_i ? '0 : wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    occ_d    = flush_i ? '0 : occ_q + OW'(wr_en) - OW'(rd_en);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Pair storage; the three fields of an entry are always written together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= '0;
        first_q[i]  <= '0;
        second_q[i] <= '0;
      end
    end else if (wr_en) begin
      pc_q[wr_ptr_q]     <= push_pc_i;
      first_q[wr_ptr_q]  <= push_first_inst_i;
      second_q[wr_ptr_q] <= push_second_inst_i;
    end
  end
endmodule

// File: tb/tb_inst_pair_queue.sv
// tb_inst_pair_queue: directed self-checking bench for inst_pair_queue (DEPTH=4)
module tb_inst_pair_queue;
  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, push_valid_i, push_ready_o, stall_i, out_valid_o;
  logic [31:0] push_pc_i, push_first_inst_i, push_second_inst_i;
  logic [31:0] out_pc_o, out_first_inst_o, out_second_inst_o;
  logic [2:0]  occupancy_o;
  int          total = 0, bad = 0;

  inst_pair_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_pc_i(push_pc_i), .push_first_inst_i(push_first_inst_i),
    .push_second_inst_i(push_second_inst_i), .stall_i(stall_i),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o),
    .out_first_inst_o(out_first_inst_o), .out_second_inst_o(out_second_inst_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    push_valid_i       = v;
    push_pc_i          = pc;
    push_first_inst_i  = 32'h1000_0000 | pc;
    push_second_inst_i = 32'h2000_0000 | pc;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 32'h55);
    repeat (3) step();
    check("rst_valid", out_valid_o, 0);
    check("rst_occ", occupancy_o, 0);
    check("rst_ready", push_ready_o, 1);
    check("rst_pc", out_pc_o, 0);
    drive(1'b0, 32'h0);
    rst_ni = 1'b1;
    step();
    check("idle_valid", out_valid_o, 0);

    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(k * 8));
      step();
      check("fill_occ", occupancy_o, 64'(k + 1));
    end
    check("fill_head", out_pc_o, 32'h00);
    check("full_ready", push_ready_o, 0);
    drive(1'b1, 32'h20);
    step();
    check("drop5_occ", occupancy_o, 4);
    drive(1'b0, 32'h0);
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", out_pc_o, 64'(k * 8));
      check("drain_first", out_first_inst_o, 64'(32'h1000_0000 | k * 8));
      check("drain_second", out_second_inst_o, 64'(32'h2000_0000 | k * 8));
      step();
    end
    check("drain_valid", out_valid_o, 0);
    check("drain_pc0", out_pc_o, 0);

    stall_i = 1'b1;
    drive(1'b1, 32'h100);
    step();
    stall_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 32'h100 + 32'(8 * k));
      check("wrap_pc", out_pc_o, 64'(32'h100 + 8 * (k - 1)));
      step();
      check("wrap_occ", occupancy_o, 1);
    end
    drive(1'b0, 32'h0);
    check("wrap_last", out_pc_o, 32'h150);
    step();
    check("wrap_empty", out_valid_o, 0);

    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h300 + 32'(8 * k));
      step();
    end
    stall_i = 1'b0;
    drive(1'b1, 32'h320);
    check("fullpop_ready", push_ready_o, 0);
    step();
    check("fullpop_occ", occupancy_o, 3);
    drive(1'b0, 32'h0);
    for (int k = 1; k < 4; k++) begin
      check("fullpop_pc", out_pc_o, 64'(32'h300 + 8 * k));
      step();
    end
    check("fullpop_empty", out_valid_o, 0);

    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hA0 + 32'(8 * k));
      step();
    end
    check("pre_flush_occ", occupancy_o, 3);
    flush_i = 1'b1; stall_i = 1'b0;
    drive(1'b1, 32'h40);
    step();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    check("flush_occ", occupancy_o, 0);
    check("flush_valid", out_valid_o, 0);
    step();
    check("flush_nopush", out_valid_o, 0);
    stall_i = 1'b1;
    drive(1'b1, 32'h200);
    step();
    drive(1'b0, 32'h0);
    check("post_flush_pc", out_pc_o, 32'h200);
    check("post_flush_occ", occupancy_o, 1);
    stall_i = 1'b0;
    step();
    check("post_flush_empty", out_valid_o, 0);

    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h60 + 32'(8 * k));
      step();
    end
    drive(1'b0, 32'h0);
    check("mid_occ", occupancy_o, 2);
    check("mid_valid", out_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_valid", out_valid_o, 0);
    check("async_occ", occupancy_o, 0);
    check("async_pc", out_pc_o, 0);
    #2 rst_ni = 1'b1;
    step();
    check("post_rst_occ", occupancy_o, 0);
    check("post_rst_ready", push_ready_o, 1);
    check("post_rst_valid", out_valid_o, 0);

    stall_i = 1'b0;
    drive(1'b1, 32'h80);
    #1;
`ifdef IPQ_BYPASS_EN
    check("byp_valid", out_valid_o, 1);
    check("byp_pc", out_pc_o, 32'h80);
    check("byp_first", out_first_inst_o, 32'h1000_0080);
    step();
    drive(1'b0, 32'h0);
    check("byp_occ", occupancy_o, 0);
    check("byp_after", out_valid_o, 0);
`else
    check("nobyp_valid", out_valid_o, 0);
    check("nobyp_pc0", out_pc_o, 0);
    step();
    drive(1'b0, 32'h0);
    check("nobyp_pc", out_pc_o, 32'h80);
    check("nobyp_occ", occupancy_o, 1);
    step();
    check("nobyp_after", out_valid_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
